// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: single-port SRAM front end with an in-order 2-deep read response buffer
module sram_port_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int WMASK_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);
    logic                  rd_pend;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] fifo [2];
    logic                  pop;
    logic                  rd_ok;
    logic                  accept;

    // Handshake and SRAM pin drive; a pop in the same cycle frees a slot so reads can stream
    always_comb begin
        rsp_valid  = count != 2'd0;
        rsp_rdata  = fifo[rd_ptr];
        pop        = rsp_valid && rsp_ready;
        rd_ok      = ((count + {1'b0, rd_pend}) < 2'd2) || pop;
        req_ready  = rst_n && (req_we || rd_ok);
        accept     = req_valid && req_ready;
        sram_we    = accept && req_we;
        sram_wmask = req_wmask;
        sram_addr  = req_addr;
        sram_din   = req_wdata;
    end

    // Track the in-flight read and capture SRAM data into the response FIFO one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            fifo[0] <= '0;
            fifo[1] <= '0;
        end else begin
            rd_pend <= accept && !req_we;
            if (rd_pend) begin
                fifo[wr_ptr] <= sram_dout;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, rd_pend} - {1'b0, pop};
        end
    end
endmodule
